// File: rtl/trap_if.sv
// Commit-stage, interrupt and CSR signals exchanged with the machine-mode trap sequencer.
// The sequencer connects through the slave modport.
interface trap_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  commit_valid;
    logic [DATA_WIDTH-1:0] commit_pc;
    logic                  exc_valid;
    logic [3:0]            exc_code;
    logic [DATA_WIDTH-1:0] exc_tval;
    logic                  mret_valid;
    logic                  ext_irq;
    logic                  sw_irq;
    logic                  timer_irq;
    logic                  mstatus_mie;
    logic                  mie_meie;
    logic                  mie_msie;
    logic                  mie_mtie;
    logic [DATA_WIDTH-3:0] mtvec_base;
    logic [1:0]            mtvec_mode;
    logic [DATA_WIDTH-1:0] mepc;
    logic                  flush;
    logic                  stall;
    logic                  take_trap;
    logic [DATA_WIDTH-1:0] trap_mepc;
    logic [DATA_WIDTH-1:0] trap_mcause;
    logic [DATA_WIDTH-1:0] trap_mtval;
    logic                  mret_done;
    logic                  pc_redirect;
    logic [DATA_WIDTH-1:0] pc_target;

    modport slave (
        input  commit_valid, commit_pc, exc_valid, exc_code, exc_tval, mret_valid,
               ext_irq, sw_irq, timer_irq, mstatus_mie, mie_meie, mie_msie, mie_mtie,
               mtvec_base, mtvec_mode, mepc,
        output flush, stall, take_trap, trap_mepc, trap_mcause, trap_mtval,
               mret_done, pc_redirect, pc_target
    );

    modport master (
        output commit_valid, commit_pc, exc_valid, exc_code, exc_tval, mret_valid,
               ext_irq, sw_irq, timer_irq, mstatus_mie, mie_meie, mie_msie, mie_mtie,
               mtvec_base, mtvec_mode, mepc,
        input  flush, stall, take_trap, trap_mepc, trap_mcause, trap_mtval,
               mret_done, pc_redirect, pc_target
    );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: arbitrates exception > interrupt > MRET at commit,
// strobes the CSR update one cycle later and redirects fetch the cycle after that.
module trap_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input logic   clk,
    input logic   rst,
    trap_if.slave bus
);
    typedef enum logic [1:0] {IDLE, TRAP, MRET, REDIRECT} state_t;

    state_t                state;
    logic                  ext_en, sw_en, tmr_en;
    logic                  exc_det, irq_det, mret_det;
    logic [3:0]            irq_cause;
    logic [DATA_WIDTH-1:0] base_addr;

    logic                  stall_r, take_trap_r, mret_done_r, pc_redirect_r;
    logic [DATA_WIDTH-1:0] mepc_r, mcause_r, mtval_r, target_r;

    function automatic logic [DATA_WIDTH-1:0] vec_target(input logic [DATA_WIDTH-1:0] base,
                                                         input logic [3:0] cause);
        return base + {{(DATA_WIDTH-6){1'b0}}, cause, 2'b00};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] irq_mcause(input logic [3:0] cause);
        return {1'b1, {(DATA_WIDTH-5){1'b0}}, cause};
    endfunction

    always_comb begin
        ext_en    = bus.ext_irq & bus.mie_meie;
        sw_en     = bus.sw_irq & bus.mie_msie;
        tmr_en    = bus.timer_irq & bus.mie_mtie;
        exc_det   = bus.commit_valid & bus.exc_valid;
        irq_det   = bus.commit_valid & bus.mstatus_mie & (ext_en | sw_en | tmr_en);
        mret_det  = bus.commit_valid & bus.mret_valid & ~bus.exc_valid;
        base_addr = {bus.mtvec_base, 2'b00};
        if (ext_en)
            irq_cause = 4'd11;
        else if (sw_en)
            irq_cause = 4'd3;
        else
            irq_cause = 4'd7;
    end

    // Flush is gated by reset so nothing is killed while the sequencer is held in reset.
    assign bus.flush       = rst & (state == IDLE) & (exc_det | irq_det | mret_det);
    assign bus.stall       = stall_r;
    assign bus.take_trap   = take_trap_r;
    assign bus.mret_done   = mret_done_r;
    assign bus.pc_redirect = pc_redirect_r;
    assign bus.trap_mepc   = mepc_r;
    assign bus.trap_mcause = mcause_r;
    assign bus.trap_mtval  = mtval_r;
    assign bus.pc_target   = target_r;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            stall_r       <= 1'b0;
            take_trap_r   <= 1'b0;
            mret_done_r   <= 1'b0;
            pc_redirect_r <= 1'b0;
            mepc_r        <= '0;
            mcause_r      <= '0;
            mtval_r       <= '0;
            target_r      <= '0;
        end else begin
            take_trap_r   <= 1'b0;
            mret_done_r   <= 1'b0;
            pc_redirect_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (exc_det) begin
                        mepc_r      <= bus.commit_pc;
                        mcause_r    <= {{(DATA_WIDTH-4){1'b0}}, bus.exc_code};
                        mtval_r     <= bus.exc_tval;
                        target_r    <= base_addr;
                        take_trap_r <= 1'b1;
                        stall_r     <= 1'b1;
                        state       <= TRAP;
                    end else if (irq_det) begin
                        mepc_r      <= bus.commit_pc;
                        mcause_r    <= irq_mcause(irq_cause);
                        mtval_r     <= '0;
                        // Modes 2 and 3 are reserved and fall back to direct.
                        target_r    <= (bus.mtvec_mode == 2'd1) ? vec_target(base_addr, irq_cause)
                                                                : base_addr;
                        take_trap_r <= 1'b1;
                        stall_r     <= 1'b1;
                        state       <= TRAP;
                    end else if (mret_det) begin
                        target_r    <= {bus.mepc[DATA_WIDTH-1:2], 2'b00};
                        mret_done_r <= 1'b1;
                        stall_r     <= 1'b1;
                        state       <= MRET;
                    end
                end
                TRAP, MRET: begin
                    pc_redirect_r <= 1'b1;
                    state         <= REDIRECT;
                end
                REDIRECT: begin
                    stall_r <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: directed events push expected strobes, a negedge monitor pops and compares.
module tb_trap_ctrl;
    localparam int DW = 32;

    typedef struct {
        int          kind;   // 0 take_trap, 1 mret_done, 2 pc_redirect
        int          cyc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    trap_if #(.DATA_WIDTH(DW)) bus ();
    trap_ctrl #(.DATA_WIDTH(DW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon_pop(input int kind);
        exp_t e;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_strobe: got strobe kind %0d, expected none (cycle %0d)", kind, cyc);
            return;
        end
        e = sb.pop_front();
        check("strobe_kind", kind, e.kind);
        check("strobe_cycle", cyc, e.cyc);
        check("stall_at_strobe", {31'd0, bus.stall}, 32'd1);
        if (kind == 0) begin
            check("trap_mepc", bus.trap_mepc, e.a);
            check("trap_mcause", bus.trap_mcause, e.b);
            check("trap_mtval", bus.trap_mtval, e.c);
        end else if (kind == 2) begin
            check("pc_target", bus.pc_target, e.a);
        end
    endtask

    always @(negedge clk) begin
        if (bus.take_trap === 1'b1)   mon_pop(0);
        if (bus.mret_done === 1'b1)   mon_pop(1);
        if (bus.pc_redirect === 1'b1) mon_pop(2);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_events();
        bus.commit_valid = 1'b0;
        bus.exc_valid    = 1'b0;
        bus.mret_valid   = 1'b0;
        bus.ext_irq      = 1'b0;
        bus.sw_irq       = 1'b0;
        bus.timer_irq    = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 8 && sb.size() != 0; i++) step();
        check({name, "_drained"}, sb.size(), 0);
    endtask

    // Caller has driven the event for the current cycle n.
    task automatic run_event(input string name, input logic [31:0] e_mepc, input logic [31:0] e_mcause,
                             input logic [31:0] e_mtval, input logic [31:0] e_target, input bit is_mret);
        int n;
        n = cyc;
        if (is_mret) sb.push_back('{1, n + 1, 32'd0, 32'd0, 32'd0});
        else         sb.push_back('{0, n + 1, e_mepc, e_mcause, e_mtval});
        sb.push_back('{2, n + 2, e_target, 32'd0, 32'd0});
        @(negedge clk);
        check({name, "_flush_n"}, {31'd0, bus.flush}, 32'd1);
        check({name, "_stall_n"}, {31'd0, bus.stall}, 32'd0);
        step();
        clear_events();
        @(negedge clk);
        check({name, "_stall_n1"}, {31'd0, bus.stall}, 32'd1);
        step();
        @(negedge clk);
        check({name, "_stall_n2"}, {31'd0, bus.stall}, 32'd1);
        step();
        @(negedge clk);
        check({name, "_stall_n3"}, {31'd0, bus.stall}, 32'd0);
        if (!is_mret) check({name, "_mepc_held"}, bus.trap_mepc, e_mepc);
        drain(name);
        step();
    endtask

    task automatic masked_run(input string name);
        logic any;
        any = 1'b0;
        bus.commit_valid = 1'b1;
        bus.ext_irq = 1'b1; bus.sw_irq = 1'b1; bus.timer_irq = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            any = any | bus.flush | bus.stall | bus.take_trap | bus.mret_done | bus.pc_redirect;
            step();
        end
        check(name, {31'd0, any}, 32'd0);
        clear_events();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        clear_events();
        bus.commit_pc = '0; bus.exc_code = '0; bus.exc_tval = '0;
        bus.mstatus_mie = 1'b0; bus.mie_meie = 1'b0; bus.mie_msie = 1'b0; bus.mie_mtie = 1'b0;
        bus.mtvec_base = 30'h80; bus.mtvec_mode = 2'd0; bus.mepc = '0;

        // Reset with an exception presented: nothing may respond.
        bus.commit_valid = 1'b1; bus.exc_valid = 1'b1;
        repeat (3) step();
        @(negedge clk);
        check("rst_flush", {31'd0, bus.flush}, 32'd0);
        check("rst_stall", {31'd0, bus.stall}, 32'd0);
        check("rst_take_trap", {31'd0, bus.take_trap}, 32'd0);
        check("rst_mret_done", {31'd0, bus.mret_done}, 32'd0);
        check("rst_pc_redirect", {31'd0, bus.pc_redirect}, 32'd0);
        check("rst_trap_mepc", bus.trap_mepc, 32'd0);
        check("rst_trap_mcause", bus.trap_mcause, 32'd0);
        check("rst_trap_mtval", bus.trap_mtval, 32'd0);
        check("rst_pc_target", bus.pc_target, 32'd0);
        clear_events();
        step();
        rst = 1'b1;
        step();

        // Illegal instruction, direct mode.
        bus.commit_pc = 32'h100; bus.exc_code = 4'd2; bus.exc_tval = 32'hDEADBEEF;
        bus.commit_valid = 1'b1; bus.exc_valid = 1'b1;
        run_event("illegal", 32'h100, 32'h2, 32'hDEADBEEF, 32'h200, 1'b0);

        // Vectored timer interrupt.
        bus.mtvec_mode = 2'd1; bus.mstatus_mie = 1'b1; bus.mie_mtie = 1'b1;
        bus.commit_pc = 32'h40; bus.timer_irq = 1'b1; bus.commit_valid = 1'b1;
        run_event("vec_timer", 32'h40, 32'h80000007, 32'h0, 32'h21C, 1'b0);

        // Masked interrupts.
        bus.mstatus_mie = 1'b0; bus.mie_meie = 1'b1; bus.mie_msie = 1'b1; bus.mie_mtie = 1'b1;
        masked_run("masked_global");
        bus.mstatus_mie = 1'b1; bus.mie_meie = 1'b0; bus.mie_msie = 1'b0; bus.mie_mtie = 1'b0;
        masked_run("masked_local");
        step();

        // Exception beats interrupts; exceptions ignore vectored mode.
        bus.mie_meie = 1'b1; bus.mie_msie = 1'b1; bus.mie_mtie = 1'b1;
        bus.commit_pc = 32'h300; bus.exc_code = 4'd11; bus.exc_tval = 32'h1234;
        bus.ext_irq = 1'b1; bus.sw_irq = 1'b1; bus.exc_valid = 1'b1; bus.commit_valid = 1'b1;
        run_event("exc_over_irq", 32'h300, 32'hB, 32'h1234, 32'h200, 1'b0);

        // External beats software, vectored.
        bus.ext_irq = 1'b1; bus.sw_irq = 1'b1; bus.commit_valid = 1'b1;
        run_event("ext_over_sw", 32'h300, 32'h8000000B, 32'h0, 32'h22C, 1'b0);

        // Software interrupt with reserved mode 2 acts as direct.
        bus.mtvec_mode = 2'd2; bus.sw_irq = 1'b1; bus.timer_irq = 1'b1; bus.commit_valid = 1'b1;
        run_event("sw_mode2", 32'h300, 32'h80000003, 32'h0, 32'h200, 1'b0);

        // MRET.
        bus.mtvec_mode = 2'd0; bus.mepc = 32'h106;
        bus.mret_valid = 1'b1; bus.commit_valid = 1'b1;
        run_event("mret", 32'h0, 32'h0, 32'h0, 32'h104, 1'b1);

        // MRET with exception takes the trap path.
        bus.commit_pc = 32'h500; bus.exc_code = 4'd2; bus.exc_tval = 32'h0;
        bus.mret_valid = 1'b1; bus.exc_valid = 1'b1; bus.commit_valid = 1'b1;
        run_event("mret_exc", 32'h500, 32'h2, 32'h0, 32'h200, 1'b0);

        // Back-to-back: exception held for four cycles is taken at n and again at n+3.
        bus.commit_pc = 32'h600; bus.exc_code = 4'd5; bus.exc_tval = 32'h77;
        bus.exc_valid = 1'b1; bus.commit_valid = 1'b1;
        n = cyc;
        sb.push_back('{0, n + 1, 32'h600, 32'h5, 32'h77});
        sb.push_back('{2, n + 2, 32'h200, 32'd0, 32'd0});
        sb.push_back('{0, n + 4, 32'h600, 32'h5, 32'h77});
        sb.push_back('{2, n + 5, 32'h200, 32'd0, 32'd0});
        step();
        @(negedge clk);
        check("b2b_flush_in_trap", {31'd0, bus.flush}, 32'd0);
        step();
        step();
        @(negedge clk);
        check("b2b_flush_n3", {31'd0, bus.flush}, 32'd1);
        step();
        clear_events();
        drain("b2b");
        step();

        // Reset during TRAP.
        bus.commit_pc = 32'h700; bus.exc_code = 4'd4; bus.exc_tval = 32'h99;
        bus.exc_valid = 1'b1; bus.commit_valid = 1'b1;
        n = cyc;
        sb.push_back('{0, n + 1, 32'h700, 32'h4, 32'h99});
        step();
        clear_events();
        rst = 1'b0;
        step();
        @(negedge clk);
        check("midrst_stall", {31'd0, bus.stall}, 32'd0);
        check("midrst_take_trap", {31'd0, bus.take_trap}, 32'd0);
        check("midrst_pc_redirect", {31'd0, bus.pc_redirect}, 32'd0);
        check("midrst_trap_mepc", bus.trap_mepc, 32'd0);
        check("midrst_pc_target", bus.pc_target, 32'd0);
        rst = 1'b1;
        step();
        step();
        check("midrst_no_redirect", sb.size(), 0);
        bus.commit_pc = 32'h800; bus.exc_code = 4'd6; bus.exc_tval = 32'h55;
        bus.exc_valid = 1'b1; bus.commit_valid = 1'b1;
        run_event("after_rst", 32'h800, 32'h6, 32'h55, 32'h200, 1'b0);

        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
